difftest_commit_checker: RTL and testbench

- In-RTL consumer for the DUT commit stream: captures per-instruction commit records from the write-back stage and compares them against reference-model records supplied by the simulation harness.
- Sits beside the WBU in simulation builds only.
- Buffers DUT commits in a FIFO, handles skip and finish events, and raises a sticky mismatch or trap verdict.

---
 rtl/difftest_pkg.sv | 33 +++
 rtl/commit_fifo.sv | 52 +++++
 rtl/difftest_commit_checker.sv | 156 +++++++++++++++
 tb/tb_difftest_commit_checker.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/difftest_pkg.sv
// Shared types for the difftest commit checker: commit record layout,
// verdict codes and checker states.
package difftest_pkg;

  localparam int          DT_XLEN    = 64;
  localparam logic [31:0] EBREAK_ENC = 32'h0010_0073;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_PC       = 3'd1,
    ERR_RD       = 3'd2,
    ERR_WDATA    = 3'd3,
    ERR_OVERFLOW = 3'd4,
    ERR_TRAP     = 3'd5
  } err_code_e;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DONE = 2'd1,
    FAIL = 2'd2
  } chk_state_e;

  typedef struct packed {
    logic [DT_XLEN-1:0] pc;
    logic [31:0]        ins;
    logic               rd_wen;
    logic [4:0]         rd;
    logic [DT_XLEN-1:0] wdata;
    logic               skip;
    logic               a0zero;
  } commit_rec_t;

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO with a register-array store; the head entry is always
// visible on o_head so the consumer can compare in the same cycle it pops.
module commit_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == FULL_LVL);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/difftest_commit_checker.sv
// Simulation-only commit checker: queues DUT retirements and compares them
// against reference records, latching the first failure and the end verdict.
module difftest_commit_checker
  import difftest_pkg::*;
#(
  parameter int          DEPTH  = 8,
  parameter int          XLEN   = DT_XLEN,
  parameter logic [31:0] EBREAK = EBREAK_ENC
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_commit,
  input  logic                     i_skip,
  input  logic [XLEN-1:0]          i_pc,
  input  logic [31:0]              i_ins,
  input  logic                     i_rd_wen,
  input  logic [4:0]               i_rd,
  input  logic [XLEN-1:0]          i_rd_wdata,
  input  logic                     i_a0zero,
  input  logic                     i_ref_valid,
  output logic                     o_ref_ready,
  input  logic [XLEN-1:0]          i_ref_pc,
  input  logic                     i_ref_rd_wen,
  input  logic [4:0]               i_ref_rd,
  input  logic [XLEN-1:0]          i_ref_wdata,
  output logic                     o_done,
  output logic                     o_pass,
  output logic                     o_fail,
  output logic [2:0]               o_err_code,
  output logic [XLEN-1:0]          o_err_pc,
  output logic [31:0]              o_commit_cnt,
  output logic [$clog2(DEPTH):0]   o_level
);

  commit_rec_t     w_in_rec;
  commit_rec_t     w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_run;
  logic            w_pop;
  logic            w_push;
  logic            w_overflow;
  logic            w_finish;
  err_code_e       w_cmp_code;

  chk_state_e      r_state;
  chk_state_e      w_state_next;
  err_code_e       r_err_code;
  err_code_e       w_err_next;
  logic [XLEN-1:0] r_err_pc;
  logic [XLEN-1:0] w_err_pc_next;
  logic            r_done;
  logic            r_pass;
  logic            w_set_done;
  logic            w_set_pass;
  logic [31:0]     r_commit_cnt;

  assign w_in_rec = '{pc: i_pc, ins: i_ins, rd_wen: i_rd_wen, rd: i_rd,
                      wdata: i_rd_wdata, skip: i_skip, a0zero: i_a0zero};

  assign w_run       = (r_state == RUN);
  assign o_ref_ready = w_run && !w_empty;
  assign w_pop       = o_ref_ready && i_ref_valid;
  assign w_overflow  = w_run && i_commit && w_full && !w_pop;
  assign w_push      = w_run && i_commit && !w_overflow;

  commit_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(commit_rec_t))
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_in_rec),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  // x0 writes are never data-checked; skipped records are never compared.
  always_comb begin
    w_cmp_code = ERR_NONE;
    if (!w_head.skip) begin
      if (w_head.pc != i_ref_pc)
        w_cmp_code = ERR_PC;
      else if ((w_head.rd_wen != i_ref_rd_wen) || (w_head.rd_wen && (w_head.rd != i_ref_rd)))
        w_cmp_code = ERR_RD;
      else if (w_head.rd_wen && (w_head.rd != 5'd0) && (w_head.wdata != i_ref_wdata))
        w_cmp_code = ERR_WDATA;
    end
  end

  assign w_finish = w_pop && (w_cmp_code == ERR_NONE) && (w_head.ins == EBREAK);

  always_comb begin
    w_state_next  = r_state;
    w_err_next    = ERR_NONE;
    w_err_pc_next = w_head.pc;
    w_set_done    = 1'b0;
    w_set_pass    = 1'b0;
    case (r_state)
      RUN: begin
        if (w_overflow) begin
          w_state_next  = FAIL;
          w_err_next    = ERR_OVERFLOW;
          w_err_pc_next = i_pc;
        end else if (w_pop && (w_cmp_code != ERR_NONE)) begin
          w_state_next = FAIL;
          w_err_next   = w_cmp_code;
        end else if (w_finish) begin
          w_set_done = 1'b1;
          if (w_head.a0zero) begin
            w_state_next = DONE;
            w_set_pass   = 1'b1;
          end else begin
            w_state_next = FAIL;
            w_err_next   = ERR_TRAP;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= RUN;
      r_err_code   <= ERR_NONE;
      r_err_pc     <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_commit_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      // First error wins; later ones never overwrite the latched record.
      if ((r_err_code == ERR_NONE) && (w_err_next != ERR_NONE)) begin
        r_err_code <= w_err_next;
        r_err_pc   <= w_err_pc_next;
      end
      if (w_set_done) r_done <= 1'b1;
      if (w_set_pass) r_pass <= 1'b1;
      if (w_pop && (r_commit_cnt != 32'hFFFF_FFFF))
        r_commit_cnt <= r_commit_cnt + 32'd1;
    end
  end

  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_fail       = (r_state == FAIL);
  assign o_err_code   = r_err_code;
  assign o_err_pc     = r_err_pc;
  assign o_commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_difftest_commit_checker.sv
// Directed bench for difftest_commit_checker with a queue-based reference
// model checked every cycle, plus literal expectations per scenario.
module tb_difftest_commit_checker;

  localparam int          DEPTH = 8;
  localparam logic [31:0] EBRK  = 32'h0010_0073;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        commit = 1'b0, skip = 1'b0, rd_wen = 1'b0, a0zero = 1'b0;
  logic [63:0] pc = '0, wdata = '0;
  logic [31:0] ins = '0;
  logic [4:0]  rd = '0;
  logic        ref_valid = 1'b0, ref_wen = 1'b0;
  logic [63:0] ref_pc = '0, ref_wd = '0;
  logic [4:0]  ref_rd = '0;
  logic        ref_ready, done, pass, fail;
  logic [2:0]  code;
  logic [63:0] err_pc;
  logic [31:0] cnt;
  logic [3:0]  level;

  difftest_commit_checker #(.DEPTH(DEPTH), .XLEN(64), .EBREAK(EBRK)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_commit(commit), .i_skip(skip),
    .i_pc(pc), .i_ins(ins), .i_rd_wen(rd_wen), .i_rd(rd), .i_rd_wdata(wdata),
    .i_a0zero(a0zero), .i_ref_valid(ref_valid), .o_ref_ready(ref_ready),
    .i_ref_pc(ref_pc), .i_ref_rd_wen(ref_wen), .i_ref_rd(ref_rd),
    .i_ref_wdata(ref_wd), .o_done(done), .o_pass(pass), .o_fail(fail),
    .o_err_code(code), .o_err_pc(err_pc), .o_commit_cnt(cnt), .o_level(level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] wd;
    logic        skip;
    logic        a0z;
  } mrec_t;

  mrec_t       mq[$];
  int          m_state = 0;   // 0 running, 1 finished clean, 2 failed
  logic        m_done = 1'b0;
  logic        m_pass = 1'b0;
  int          m_code = 0;
  logic [63:0] m_errpc = '0;
  longint      m_cnt = 0;

  task automatic model_clear();
    mq.delete();
    m_state = 0; m_done = 1'b0; m_pass = 1'b0;
    m_code = 0; m_errpc = '0; m_cnt = 0;
  endtask

  task automatic model_fail(input int c, input logic [63:0] p);
    if (m_code == 0) begin
      m_code  = c;
      m_errpc = p;
    end
    m_state = 2;
  endtask

  task automatic model_step();
    bit    was_run;
    bit    pop;
    int    c;
    mrec_t h;
    was_run = (m_state == 0);
    pop     = was_run && (mq.size() > 0) && ref_valid;
    c       = 0;
    if (pop) begin
      h = mq.pop_front();
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (!h.skip) begin
        if (h.pc !== ref_pc) c = 1;
        else if (h.wen !== ref_wen || (h.wen && h.rd !== ref_rd)) c = 2;
        else if (h.wen && h.rd != 0 && h.wd !== ref_wd) c = 3;
      end
      if (c != 0) model_fail(c, h.pc);
      else if (h.ins == EBRK) begin
        m_done = 1'b1;
        if (h.a0z) begin m_state = 1; m_pass = 1'b1; end
        else model_fail(5, h.pc);
      end
    end
    if (was_run && commit) begin
      if (mq.size() == DEPTH && !pop) model_fail(4, pc);
      else mq.push_back('{pc: pc, ins: ins, wen: rd_wen, rd: rd, wd: wdata, skip: skip, a0z: a0zero});
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_clear();
    else model_step();
  end

  always @(negedge clk) begin
    chk("level",  64'(level),     64'(mq.size()));
    chk("ready",  64'(ref_ready), 64'(m_state == 0 && mq.size() > 0));
    chk("done",   64'(done),      64'(m_done));
    chk("pass",   64'(pass),      64'(m_pass));
    chk("fail",   64'(fail),      64'(m_state == 2));
    chk("code",   64'(code),      64'(m_code));
    chk("err_pc", err_pc,         m_errpc);
    chk("cnt",    64'(cnt),       64'(m_cnt));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    commit = 1'b0; skip = 1'b0; a0zero = 1'b0; ref_valid = 1'b0;
  endtask

  task automatic put(input logic [63:0] p, input logic [31:0] in, input logic w,
                     input logic [4:0] r, input logic [63:0] d, input logic s, input logic a);
    commit = 1'b1; pc = p; ins = in; rd_wen = w; rd = r; wdata = d; skip = s; a0zero = a;
  endtask

  task automatic give(input logic [63:0] p, input logic w, input logic [4:0] r, input logic [63:0] d);
    ref_valid = 1'b1; ref_pc = p; ref_wen = w; ref_rd = r; ref_wd = d;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_fail",  64'(fail),  64'd0);
    chk("rst_done",  64'(done),  64'd0);
    chk("rst_code",  64'(code),  64'd0);
    chk("rst_cnt",   64'(cnt),   64'd0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // three matching commits
    do_reset();
    put(64'h8000_0000, NOP, 1'b1, 5'd5, 64'h1234, 1'b0, 1'b0); tick();
    put(64'h8000_0004, NOP, 1'b1, 5'd5, 64'h1234, 1'b0, 1'b0);
    give(64'h8000_0000, 1'b1, 5'd5, 64'h1234); tick();
    put(64'h8000_0008, NOP, 1'b1, 5'd5, 64'h1234, 1'b0, 1'b0);
    give(64'h8000_0004, 1'b1, 5'd5, 64'h1234); tick();
    give(64'h8000_0008, 1'b1, 5'd5, 64'h1234); tick();
    tick();
    chk("s1_cnt", 64'(cnt), 64'd3);
    chk("s1_fail", 64'(fail), 64'd0);
    chk("s1_level", 64'(level), 64'd0);

    // wdata mismatch on second record, later mismatches ignored
    do_reset();
    put(64'h8000_0000, NOP, 1'b1, 5'd5, 64'h1234, 1'b0, 1'b0); tick();
    put(64'h8000_0004, NOP, 1'b1, 5'd5, 64'h1234, 1'b0, 1'b0);
    give(64'h8000_0000, 1'b1, 5'd5, 64'h1234); tick();
    put(64'h8000_0008, NOP, 1'b1, 5'd5, 64'h1234, 1'b0, 1'b0);
    give(64'h8000_0004, 1'b1, 5'd5, 64'h1235); tick();
    put(64'h8000_000C, NOP, 1'b1, 5'd7, 64'h1, 1'b0, 1'b0);
    give(64'hDEAD_0000, 1'b0, 5'd0, 64'h0); tick();
    give(64'hBEEF_0000, 1'b1, 5'd1, 64'h9); tick();
    tick();
    chk("s2_fail", 64'(fail), 64'd1);
    chk("s2_code", 64'(code), 64'd3);
    chk("s2_err_pc", err_pc, 64'h8000_0004);
    chk("s2_ready", 64'(ref_ready), 64'd0);
    chk("s2_cnt", 64'(cnt), 64'd2);

    // skipped record with wrong ref PC, then a match, then an x0 write
    do_reset();
    put(64'h8000_0000, NOP, 1'b1, 5'd5, 64'h1234, 1'b1, 1'b0); tick();
    put(64'h8000_0004, NOP, 1'b1, 5'd6, 64'h55, 1'b0, 1'b0);
    give(64'h1111_0000, 1'b0, 5'd0, 64'h0); tick();
    put(64'h8000_0008, NOP, 1'b1, 5'd0, 64'hAA, 1'b0, 1'b0);
    give(64'h8000_0004, 1'b1, 5'd6, 64'h55); tick();
    give(64'h8000_0008, 1'b1, 5'd0, 64'hBB); tick();
    tick();
    chk("s3_fail", 64'(fail), 64'd0);
    chk("s3_cnt", 64'(cnt), 64'd3);

    // overflow on the ninth push with no consumer
    do_reset();
    for (int i = 0; i < 9; i++) begin
      put(64'h8000_0000 + 64'(4 * i), NOP, 1'b1, 5'd5, 64'(i), 1'b0, 1'b0);
      tick();
    end
    tick();
    chk("s4_fail", 64'(fail), 64'd1);
    chk("s4_code", 64'(code), 64'd4);
    chk("s4_err_pc", err_pc, 64'h8000_0020);
    chk("s4_level", 64'(level), 64'd8);

    // push and pop together while full is legal
    do_reset();
    for (int i = 0; i < 8; i++) begin
      put(64'h8000_0000 + 64'(4 * i), NOP, 1'b1, 5'd5, 64'(i), 1'b0, 1'b0);
      tick();
    end
    put(64'h8000_0020, NOP, 1'b1, 5'd5, 64'd8, 1'b0, 1'b0);
    give(64'h8000_0000, 1'b1, 5'd5, 64'd0); tick();
    chk("s4b_level", 64'(level), 64'd8);
    chk("s4b_fail", 64'(fail), 64'd0);
    chk("s4b_cnt", 64'(cnt), 64'd1);

    // EBREAK with a0 == 0 passes
    do_reset();
    put(64'h8000_000C, NOP, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0); tick();
    put(64'h8000_0010, EBRK, 1'b0, 5'd0, 64'h0, 1'b0, 1'b1);
    give(64'h8000_000C, 1'b0, 5'd0, 64'h0); tick();
    give(64'h8000_0010, 1'b0, 5'd0, 64'h0); tick();
    put(64'h8000_0014, NOP, 1'b1, 5'd3, 64'h3, 1'b0, 1'b0); tick();
    tick();
    chk("s5_done", 64'(done), 64'd1);
    chk("s5_pass", 64'(pass), 64'd1);
    chk("s5_fail", 64'(fail), 64'd0);
    chk("s5_level", 64'(level), 64'd0);

    // EBREAK with a0 != 0 is a bad trap
    do_reset();
    put(64'h8000_000C, NOP, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0); tick();
    put(64'h8000_0010, EBRK, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0);
    give(64'h8000_000C, 1'b0, 5'd0, 64'h0); tick();
    give(64'h8000_0010, 1'b0, 5'd0, 64'h0); tick();
    tick();
    chk("s6_fail", 64'(fail), 64'd1);
    chk("s6_code", 64'(code), 64'd5);
    chk("s6_done", 64'(done), 64'd1);
    chk("s6_pass", 64'(pass), 64'd0);
    chk("s6_err_pc", err_pc, 64'h8000_0010);

    // reset with four entries queued, then resume
    do_reset();
    for (int i = 0; i < 4; i++) begin
      put(64'h8000_0000 + 64'(4 * i), NOP, 1'b1, 5'd5, 64'h1234, 1'b0, 1'b0);
      tick();
    end
    chk("s7_level_pre", 64'(level), 64'd4);
    do_reset();
    put(64'h8000_0100, NOP, 1'b1, 5'd9, 64'h77, 1'b0, 1'b0); tick();
    put(64'h8000_0104, NOP, 1'b1, 5'd9, 64'h78, 1'b0, 1'b0);
    give(64'h8000_0100, 1'b1, 5'd9, 64'h77); tick();
    give(64'h8000_0104, 1'b1, 5'd9, 64'h78); tick();
    tick();
    chk("s7_cnt", 64'(cnt), 64'd2);
    chk("s7_fail", 64'(fail), 64'd0);
    chk("s7_level", 64'(level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
